alu181_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-slice 74181 ALU. Operands are WIDTH bits wide.
- Operands are processed as 4-bit 74181-equivalent slices, LSB slice first, SLICES_PER_CYCLE slices per clock.
- Carry, group propagate and group generate are carried between cycles in registers.
- Sits between the pad-level operand registers and the result/flag outputs. Uses a valid/ready handshake on both sides.

---
 rtl/alu181_seq.sv | 150 +++++++++++++++
 tb/tb_alu181_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_seq.sv
// alu181_seq: multi-cycle 74181-style ALU, SLICES_PER_CYCLE 4-bit slices per clock, LSB first.
// Carry and the word propagate/generate accumulators ripple between cycles through registers.
module alu181_seq #(
   parameter int WIDTH            = 16,
   parameter int SLICES_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             carry_n_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             carry_n_out,
   output logic             eq,
   output logic             pout_n,
   output logic             gout_n
);
   localparam int GW    = 4 * SLICES_PER_CYCLE;
   localparam int STEPS = WIDTH / GW;
   localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   state_t r_state, w_state_nxt;

   logic [WIDTH-1:0] r_a, r_b, r_work, r_f;
   logic [3:0]       r_s;
   logic             r_m;
   logic [IW-1:0]    r_idx;
   logic             r_carry, r_p_acc, r_g_acc;
   logic             r_cn_out, r_eq, r_pout_n, r_gout_n;

   logic             w_accept, w_step, w_last;
   logic [GW-1:0]    w_grp;
   logic             w_c, w_p, w_g;
   logic [WIDTH-1:0] w_final;
   logic [3:0]       w_av, w_bv, w_x, w_y;
   logic [4:0]       w_sum, w_gsum;
   int               w_base;

   assign w_accept = ena & in_valid & (r_state == IDLE);
   assign w_step   = ena & (r_state == RUN);
   assign w_last   = (r_idx == LAST_IDX);

   // Evaluate this cycle's slices, chaining carry and P/G from the registered values
   always_comb begin
      w_c    = r_carry;
      w_p    = r_p_acc;
      w_g    = r_g_acc;
      w_grp  = '0;
      w_av   = '0;
      w_bv   = '0;
      w_x    = '0;
      w_y    = '0;
      w_sum  = '0;
      w_gsum = '0;
      w_base = int'(r_idx) * GW;
      for (int j = 0; j < SLICES_PER_CYCLE; j++) begin
         w_av   = r_a[w_base + 4*j +: 4];
         w_bv   = r_b[w_base + 4*j +: 4];
         w_x    = w_av | (w_bv & {4{r_s[0]}}) | (~w_bv & {4{r_s[1]}});
         w_y    = (w_av & ~w_bv & {4{r_s[2]}}) | (w_av & w_bv & {4{r_s[3]}});
         w_sum  = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, w_c};
         w_gsum = {1'b0, w_x} + {1'b0, w_y};
         w_grp[4*j +: 4] = r_m ? ~(w_x ^ w_y) : w_sum[3:0];
         w_c    = w_sum[4];
         w_g    = w_gsum[4] | ((&w_x) & w_g);
         w_p    = w_p & (&w_x);
      end
      w_final = r_work;
      w_final[w_base +: GW] = w_grp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (ena) begin
         case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready    = (r_state == IDLE);
      out_valid   = (r_state == DONE);
      f           = r_f;
      carry_n_out = r_cn_out;
      eq          = r_eq;
      pout_n      = r_pout_n;
      gout_n      = r_gout_n;
   end

   // Result and flags are only updated on the last slice, so no partial word is ever visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_p_acc  <= 1'b1;
         r_g_acc  <= 1'b0;
         r_f      <= '0;
         r_cn_out <= 1'b1;
         r_eq     <= 1'b0;
         r_pout_n <= 1'b1;
         r_gout_n <= 1'b1;
      end else if (w_accept) begin
         r_idx    <= '0;
         r_carry  <= ~carry_n_in;
         r_p_acc  <= 1'b1;
         r_g_acc  <= 1'b0;
      end else if (w_step) begin
         r_idx    <= r_idx + 1'b1;
         r_carry  <= w_c;
         r_p_acc  <= w_p;
         r_g_acc  <= w_g;
         if (w_last) begin
            r_f      <= w_final;
            r_cn_out <= r_m | ~w_c;
            r_eq     <= &w_final;
            r_pout_n <= ~w_p;
            r_gout_n <= ~w_g;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= a;
         r_b <= b;
         r_s <= s;
         r_m <= m;
      end else if (w_step) begin
         r_work <= w_final;
      end
   end
endmodule

// File: tb/tb_alu181_seq.sv
// Table-driven bench for alu181_seq with a result scoreboard; covers a 16-bit/1-slice
// and a 32-bit/2-slice instance.
module tb_alu181_seq;
   logic        clk = 1'b0;
   logic        rst_n, ena, in_valid, out_ready, m, cn;
   logic [3:0]  s;
   logic [15:0] a, b, f;
   logic        in_ready, out_valid, cno, eq, pn, gn;

   logic        in_valid2, out_ready2, cn2;
   logic [31:0] a2, b2, f2;
   logic        in_ready2, out_valid2, cno2, eq2, pn2, gn2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] f;
      logic        cno, eq, pn, gn;
   } exp_t;

   typedef struct {
      logic [15:0] a, b;
      logic [3:0]  s;
      logic        m, cn;
      logic [15:0] f;
      logic        cno, eq;
   } vec_t;

   exp_t q[$];
   vec_t tv[9];

   always #5 clk = ~clk;

   alu181_seq #(.WIDTH(16), .SLICES_PER_CYCLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .s(s), .m(m), .carry_n_in(cn), .out_valid(out_valid),
      .out_ready(out_ready), .f(f), .carry_n_out(cno), .eq(eq), .pout_n(pn), .gout_n(gn)
   );

   alu181_seq #(.WIDTH(32), .SLICES_PER_CYCLE(2)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .s(s), .m(m), .carry_n_in(cn2), .out_valid(out_valid2),
      .out_ready(out_ready2), .f(f2), .carry_n_out(cno2), .eq(eq2), .pout_n(pn2), .gout_n(gn2)
   );

   function automatic logic [1:0] pg16(input logic [15:0] va, input logic [15:0] vb,
                                       input logic [3:0] vs);
      logic [15:0] x, y;
      logic [16:0] t;
      x = va | (vb & {16{vs[0]}}) | (~vb & {16{vs[1]}});
      y = (va & ~vb & {16{vs[2]}}) | (va & vb & {16{vs[3]}});
      t = {1'b0, x} + {1'b0, y};
      return {~(&x), ~t[16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue16(input vec_t v);
      exp_t e;
      logic [1:0] pg;
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_idle", in_ready, 1);
      pg = pg16(v.a, v.b, v.s);
      e.f = {16'h0, v.f}; e.cno = v.cno; e.eq = v.eq; e.pn = pg[1]; e.gn = pg[0];
      a = v.a; b = v.b; s = v.s; m = v.m; cn = v.cn;
      in_valid = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'hA5A5; b = 16'h5A5A; s = 4'd3; m = ~v.m; cn = ~v.cn;
   endtask

   task automatic collect16(input string tag, input int exp_lat, input int hold);
      exp_t e;
      int cyc = 0;
      while (cyc < 60) begin
         @(posedge clk);
         cyc++;
         #1;
         if (out_valid) break;
      end
      chk({tag, "_latency"}, cyc, exp_lat);
      chk({tag, "_out_valid"}, out_valid, 1);
      if (q.size() == 0) begin
         chk({tag, "_scoreboard_nonempty"}, 0, 1);
      end else begin
         e = q.pop_front();
         chk({tag, "_f"}, {16'h0, f}, e.f);
         chk({tag, "_cno"}, cno, e.cno);
         chk({tag, "_eq"}, eq, e.eq);
         chk({tag, "_pout_n"}, pn, e.pn);
         chk({tag, "_gout_n"}, gn, e.gn);
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
            chk({tag, "_hold_f"}, {16'h0, f}, e.f);
            chk({tag, "_hold_flags"}, {cno, eq, pn, gn}, {e.cno, e.eq, e.pn, e.gn});
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_idle_in_ready"}, in_ready, 1);
      chk({tag, "_idle_out_valid"}, out_valid, 0);
   endtask

   task automatic run32(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input exp_t e);
      exp_t g;
      int cyc = 0;
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready2, 1);
      a2 = va; b2 = vb; s = 4'd9; m = 1'b0; cn2 = 1'b1;
      in_valid2 = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      a2 = '0; b2 = '0;
      while (cyc < 60) begin
         @(posedge clk);
         cyc++;
         #1;
         if (out_valid2) break;
      end
      chk({tag, "_latency"}, cyc, 4);
      if (q.size() == 0) begin
         chk({tag, "_scoreboard_nonempty"}, 0, 1);
      end else begin
         g = q.pop_front();
         chk({tag, "_f"}, f2, g.f);
         chk({tag, "_flags"}, {cno2, eq2, pn2, gn2}, {g.cno, g.eq, g.pn, g.gn});
      end
      out_ready2 = 1'b1;
      @(posedge clk);
      #1;
      out_ready2 = 1'b0;
      chk({tag, "_idle"}, {in_ready2, out_valid2}, 2'b10);
   endtask

   initial begin
      exp_t e32;
      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; s = '0; m = 1'b0; cn = 1'b1;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cn2 = 1'b1;

      tv[0] = '{16'h1234, 16'h0FFF, 4'd9,  1'b0, 1'b1, 16'h2233, 1'b1, 1'b0};
      tv[1] = '{16'hFFFF, 16'h0001, 4'd9,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      tv[2] = '{16'h5000, 16'h5000, 4'd6,  1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
      tv[3] = '{16'h5000, 16'h5000, 4'd6,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tv[4] = '{16'hF0F0, 16'hFF00, 4'd6,  1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0};
      tv[5] = '{16'hF0F0, 16'hFF00, 4'd11, 1'b1, 1'b1, 16'hF000, 1'b1, 1'b0};
      tv[6] = '{16'hF0F0, 16'hFF00, 4'd14, 1'b1, 1'b0, 16'hFFF0, 1'b1, 1'b0};
      tv[7] = '{16'hF0F0, 16'hFF00, 4'd0,  1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b0};
      tv[8] = '{16'h7FFF, 16'h0000, 4'd0,  1'b0, 1'b0, 16'h8000, 1'b1, 1'b0};

      #12;
      chk("reset_ctrl", {in_ready, out_valid}, 2'b10);
      chk("reset_f", {16'h0, f}, 32'h0);
      chk("reset_flags", {cno, eq, pn, gn}, 4'b1011);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         issue16(tv[i]);
         collect16($sformatf("vec%0d", i), 4, 0);
      end

      // Result held under backpressure; in_valid pulse during RUN must be ignored
      issue16(tv[0]);
      fork
         collect16("hs", 4, 3);
         begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h0000; b = 16'h0000;
            @(negedge clk);
            in_valid = 1'b0;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      chk("hs_no_phantom", out_valid, 0);

      // Reset asserted in the second RUN cycle
      issue16(tv[1]);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {in_ready, out_valid}, 2'b10);
      chk("midrst_f", {16'h0, f}, 32'h0);
      chk("midrst_flags", {cno, eq, pn, gn}, 4'b1011);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("midrst_no_result", {in_ready, out_valid}, 2'b10);

      // Clock enable dropped for two cycles mid-RUN
      issue16(tv[0]);
      fork
         collect16("ena", 6, 0);
         begin
            @(posedge clk);
            @(negedge clk);
            ena = 1'b0;
            repeat (2) @(negedge clk);
            ena = 1'b1;
         end
      join

      e32.f = 32'h0000_0000; e32.cno = 1'b0; e32.eq = 1'b0; e32.pn = 1'b0; e32.gn = 1'b0;
      run32("w32_ovf", 32'hFFFF_FFFF, 32'h0000_0001, e32);
      e32.f = 32'h9BE0_2467; e32.cno = 1'b1; e32.eq = 1'b0; e32.pn = 1'b1; e32.gn = 1'b1;
      run32("w32_add", 32'h89AB_CDEF, 32'h1234_5678, e32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
